// File: rtl/coord_digit_capture_if.sv
// Parser-side bus of the coordinate digit capture block: character strobes in,
// committed BCD field and fix/error pulses out.
interface coord_digit_capture_if #(
  parameter int NUM_DIGITS = 8,
  parameter int PW         = $clog2(NUM_DIGITS + 1)
);
  logic                    field_start;
  logic                    char_valid;
  logic [7:0]              char_in;
  logic                    field_end;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [PW-1:0]           point_pos;
  logic [PW-1:0]           digit_count;
  logic                    fix_valid;
  logic                    fix_err;

  modport master (
    output field_start, char_valid, char_in, field_end,
    input  digits_out, point_pos, digit_count, fix_valid, fix_err
  );

  modport slave (
    input  field_start, char_valid, char_in, field_end,
    output digits_out, point_pos, digit_count, fix_valid, fix_err
  );
endinterface

// File: rtl/coord_digit_capture.sv
// Captures one ASCII coordinate field into shadow BCD digits and commits it
// atomically on field_end, or reports fix_err if the field is malformed.
module coord_digit_slot #(
  parameter logic [3:0] DEFAULT_DIGIT = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr,
  input  logic       commit,
  input  logic [3:0] din,
  output logic [3:0] digit
);
  logic [3:0] shadow, nxt;

  // Commit takes the post-character value so a digit arriving with field_end lands.
  always_comb nxt = wr ? din : (clr ? 4'd0 : shadow);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= 4'd0;
      digit  <= DEFAULT_DIGIT;
    end else begin
      shadow <= nxt;
      if (commit) digit <= nxt;
    end
  end
endmodule

module coord_digit_capture #(
  parameter int         NUM_DIGITS    = 8,
  parameter logic [3:0] DEFAULT_DIGIT = 4'd1,
  parameter int         PW            = $clog2(NUM_DIGITS + 1)
) (
  input logic                  clk,
  input logic                  rst,
  coord_digit_capture_if.slave bus
);
  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t        state;
  logic [PW-1:0] cnt, point;
  logic          seen_point, bad;

  logic          active, is_digit, is_dot, is_other;
  logic [PW-1:0] base_cnt, base_point;
  logic          base_seen, base_bad;
  logic          dig_wr;
  logic [PW-1:0] n_cnt, n_point;
  logic          n_seen, n_bad;
  logic          commit_now, accept;

  logic [NUM_DIGITS-1:0][3:0] committed;

  // A start (in either state) wipes the field before the same-cycle character applies.
  always_comb begin
    active     = bus.field_start || (state == CAPTURE);
    is_digit   = bus.char_valid && (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
    is_dot     = bus.char_valid && (bus.char_in == 8'h2E);
    is_other   = bus.char_valid && !is_digit && !is_dot;

    base_cnt   = bus.field_start ? '0   : cnt;
    base_point = bus.field_start ? '0   : point;
    base_seen  = bus.field_start ? 1'b0 : seen_point;
    base_bad   = bus.field_start ? 1'b0 : bad;

    dig_wr     = active && is_digit && (base_cnt < PW'(NUM_DIGITS));
    n_cnt      = base_cnt + PW'(dig_wr);
    n_point    = (is_dot && !base_seen) ? base_cnt : base_point;
    n_seen     = base_seen || is_dot;
    n_bad      = base_bad || is_other || (is_dot && base_seen);

    commit_now = (state == CAPTURE) && bus.field_end && !bus.field_start;
    accept     = commit_now && !n_bad && (n_cnt != '0);
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    coord_digit_slot #(.DEFAULT_DIGIT(DEFAULT_DIGIT)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .clr    (bus.field_start),
      .wr     (dig_wr && (base_cnt == PW'(i))),
      .commit (accept),
      .din    (bus.char_in[3:0]),
      .digit  (committed[NUM_DIGITS-1-i])
    );
  end

  assign bus.digits_out = committed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      point           <= '0;
      seen_point      <= 1'b0;
      bad             <= 1'b0;
      bus.point_pos   <= '0;
      bus.digit_count <= '0;
      bus.fix_valid   <= 1'b0;
      bus.fix_err     <= 1'b0;
    end else begin
      bus.fix_valid <= accept;
      bus.fix_err   <= commit_now && !accept;
      if (active) begin
        cnt        <= n_cnt;
        point      <= n_point;
        seen_point <= n_seen;
        bad        <= n_bad;
      end
      if (bus.field_start)  state <= CAPTURE;
      else if (commit_now)  state <= IDLE;
      if (accept) begin
        bus.digit_count <= n_cnt;
        bus.point_pos   <= n_seen ? n_point : n_cnt;
      end
    end
  end
endmodule

// File: tb/tb_coord_digit_capture.sv
// Scoreboard bench: stimulus pushes expected commits/errors, monitors pop and
// compare on every fix_valid/fix_err pulse.
module tb_coord_digit_capture;
  logic clk, rst;
  logic fs, cv, fe, sel;
  logic [7:0] ci;

  coord_digit_capture_if #(.NUM_DIGITS(8)) bus8 ();
  coord_digit_capture_if #(.NUM_DIGITS(4)) bus4 ();

  assign bus8.field_start = fs & ~sel;
  assign bus8.char_valid  = cv & ~sel;
  assign bus8.field_end   = fe & ~sel;
  assign bus8.char_in     = ci;
  assign bus4.field_start = fs & sel;
  assign bus4.char_valid  = cv & sel;
  assign bus4.field_end   = fe & sel;
  assign bus4.char_in     = ci;

  coord_digit_capture #(.NUM_DIGITS(8), .DEFAULT_DIGIT(4'd1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  coord_digit_capture #(.NUM_DIGITS(4), .DEFAULT_DIGIT(4'd1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic        err;
    logic [31:0] d;
    logic [3:0]  pt;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] c, input logic e);
    fs = s; cv = v; ci = c; fe = e;
    @(posedge clk); #1;
    fs = 1'b0; cv = 1'b0; fe = 1'b0; ci = 8'h00;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i], 1'b0);
  endtask

  task automatic push8(input logic err, input logic [31:0] d, input logic [3:0] pt, input logic [3:0] cnt);
    exp_t e;
    e.err = err; e.d = d; e.pt = pt; e.cnt = cnt;
    q8.push_back(e);
  endtask

  // Monitor for the 8-digit instance
  always @(negedge clk) begin
    exp_t e;
    if (bus8.fix_valid && bus8.fix_err) begin
      checks++; errors++;
      $display("FAIL pulse_overlap8: fix_valid and fix_err both high");
    end else if (bus8.fix_valid || bus8.fix_err) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse8: valid=%b err=%b digits=%h with nothing expected",
                 bus8.fix_valid, bus8.fix_err, bus8.digits_out);
      end else begin
        e = q8.pop_front();
        if (bus8.fix_err !== e.err || bus8.digits_out !== e.d ||
            bus8.point_pos !== e.pt || bus8.digit_count !== e.cnt) begin
          errors++;
          $display("FAIL commit8: got err=%b digits=%h pt=%0d cnt=%0d expected err=%b digits=%h pt=%0d cnt=%0d",
                   bus8.fix_err, bus8.digits_out, bus8.point_pos, bus8.digit_count,
                   e.err, e.d, e.pt, e.cnt);
        end
      end
    end
  end

  // Monitor for the 4-digit instance
  always @(negedge clk) begin
    exp_t e;
    if (bus4.fix_valid || bus4.fix_err) begin
      checks++;
      if (q4.size() == 0 || bus4.fix_valid === bus4.fix_err) begin
        errors++;
        $display("FAIL unexpected_pulse4: valid=%b err=%b digits=%h",
                 bus4.fix_valid, bus4.fix_err, bus4.digits_out);
      end else begin
        e = q4.pop_front();
        if (bus4.fix_err !== e.err || {16'h0, bus4.digits_out} !== e.d ||
            {1'b0, bus4.point_pos} !== e.pt || {1'b0, bus4.digit_count} !== e.cnt) begin
          errors++;
          $display("FAIL commit4: got err=%b digits=%h pt=%0d cnt=%0d expected err=%b digits=%h pt=%0d cnt=%0d",
                   bus4.fix_err, bus4.digits_out, bus4.point_pos, bus4.digit_count,
                   e.err, e.d, e.pt, e.cnt);
        end
      end
    end
  end

  initial begin
    exp_t e4;
    rst = 1'b1; fs = 1'b0; cv = 1'b0; fe = 1'b0; ci = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits8", bus8.digits_out, 32'h11111111);
    chk("reset_point8", {28'h0, bus8.point_pos}, 32'h0);
    chk("reset_count8", {28'h0, bus8.digit_count}, 32'h0);
    chk("reset_digits4", {16'h0, bus4.digits_out}, 32'h00001111);

    // basic field with a decimal point
    push8(1'b0, 32'h49164512, 4'd4, 4'd8);
    step(1'b1, 1'b0, 8'h00, 1'b0); send("4916.4512"); step(1'b0, 1'b0, 8'h00, 1'b1);

    // last digit shares the cycle with field_end
    push8(1'b0, 32'h12500000, 4'd2, 4'd3);
    step(1'b1, 1'b0, 8'h00, 1'b0); send("12."); step(1'b0, 1'b1, "5", 1'b1);

    // rejected fields keep the prior commit
    push8(1'b1, 32'h12500000, 4'd2, 4'd3);
    step(1'b1, 1'b0, 8'h00, 1'b0); send("49A6"); step(1'b0, 1'b0, 8'h00, 1'b1);
    push8(1'b1, 32'h12500000, 4'd2, 4'd3);
    step(1'b1, 1'b0, 8'h00, 1'b0); send("1.2.3"); step(1'b0, 1'b0, 8'h00, 1'b1);
    push8(1'b1, 32'h12500000, 4'd2, 4'd3);
    step(1'b1, 1'b0, 8'h00, 1'b0); step(1'b0, 1'b0, 8'h00, 1'b1);

    // overflow truncates, no point -> point = count
    push8(1'b0, 32'h12345678, 4'd8, 4'd8);
    step(1'b1, 1'b0, 8'h00, 1'b0); send("123456789"); step(1'b0, 1'b0, 8'h00, 1'b1);

    // restart mid-field, only the second field commits
    push8(1'b0, 32'h70000000, 4'd1, 4'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0); send("55");
    step(1'b1, 1'b0, 8'h00, 1'b0); send("7"); step(1'b0, 1'b0, 8'h00, 1'b1);

    // field_end while idle does nothing
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // character in the start cycle belongs to the new field
    push8(1'b0, 32'h62000000, 4'd2, 4'd2);
    step(1'b1, 1'b1, "6", 1'b0); send("2"); step(1'b0, 1'b0, 8'h00, 1'b1);

    // start and end together: start wins, old field dropped silently
    push8(1'b0, 32'h30000000, 4'd1, 4'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0); send("9");
    step(1'b1, 1'b0, 8'h00, 1'b1); send("3"); step(1'b0, 1'b0, 8'h00, 1'b1);

    // reset mid-field discards it, later end is ignored
    step(1'b1, 1'b0, 8'h00, 1'b0); send("4916");
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_mid_digits8", bus8.digits_out, 32'h11111111);
    chk("rst_mid_point8", {28'h0, bus8.point_pos}, 32'h0);
    chk("rst_mid_count8", {28'h0, bus8.digit_count}, 32'h0);

    // 4-digit instance
    sel = 1'b1;
    e4.err = 1'b0; e4.d = 32'h00000123; e4.pt = 4'd4; e4.cnt = 4'd4;
    q4.push_back(e4);
    step(1'b1, 1'b0, 8'h00, 1'b0); send("0123"); step(1'b0, 1'b0, 8'h00, 1'b1);
    sel = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    chk("final_digits8", bus8.digits_out, 32'h11111111);
    chk("final_digits4", {16'h0, bus4.digits_out}, 32'h00000123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/coord_digit_capture.md
COORD_DIGIT_CAPTURE -- requirements
Module: coord_digit_capture

Interface
REQ-001 Parameter NUM_DIGITS, default 8, SHALL set the number of BCD digits captured per field (legal range 2..16).
REQ-002 Parameter DEFAULT_DIGIT, default 4'd1, SHALL set the reset value of every output digit.
REQ-003 Parameter PW = $clog2(NUM_DIGITS+1) SHALL set the width of the count and point outputs.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: the reset; it SHALL be synchronous and active-high.
REQ-006 Port field_start, input, 1 bit: one-cycle pulse from the parser that opens a coordinate field.
REQ-007 Port char_valid, input, 1 bit: qualifies char_in for one cycle.
REQ-008 Port char_in, input, 8 bits: ASCII character of the current field.
REQ-009 Port field_end, input, 1 bit: one-cycle pulse that closes the field (the parser's new_fix).
REQ-010 Port digits_out, output, 4*NUM_DIGITS bits: committed BCD digits; digit 0 (most significant) in the top nibble.
REQ-011 Port point_pos, output, PW bits: number of digits that preceded '.' in the committed field.
REQ-012 Port digit_count, output, PW bits: number of digits actually received in the committed field.
REQ-013 Port fix_valid, output, 1 bit: one-cycle pulse on each commit.
REQ-014 Port fix_err, output, 1 bit: one-cycle pulse on each rejected field.

Function
REQ-015 The FSM SHALL have two states, IDLE and CAPTURE; reset SHALL enter IDLE.
REQ-016 IDLE: field_start SHALL clear the shadow digits to 0, clear the digit count, clear seen_point and bad, and enter CAPTURE; all other inputs SHALL be ignored.
REQ-017 CAPTURE: a char_valid with char_in '0'..'9' (8'h30..8'h39) SHALL write char_in-8'h30 into shadow digit [count] and increment count while count < NUM_DIGITS.
REQ-018 A digit arriving when count = NUM_DIGITS SHALL be dropped, with count saturating (truncation, not an error).
REQ-019 The first '.' (8'h2E) SHALL latch point = count and set seen_point; a second '.' SHALL set bad.
REQ-020 Any other character SHALL set bad.
REQ-021 field_end in CAPTURE with bad clear SHALL copy the shadow digits to digits_out, copy count to digit_count, set point_pos to point (or to count if no '.' was seen), pulse fix_valid, and return to IDLE.
REQ-022 Unfilled low digits SHALL read 0 in digits_out (e.g. 5 digits captured of 8 gives digits 5..7 = 0).
REQ-023 field_end in CAPTURE with bad set, or with count = 0, SHALL leave digits_out, point_pos and digit_count unchanged, pulse fix_err, and return to IDLE.
REQ-024 Latency: digits_out and fix_valid (or fix_err) SHALL change on the same edge that samples field_end, and the pulse SHALL last exactly one cycle.
REQ-025 If char_valid and field_end are asserted together, the character SHALL be processed first and included in the commit decision.
REQ-026 field_start in CAPTURE SHALL discard the partial field and restart capture; no fix_valid or fix_err pulse SHALL be generated.
REQ-027 If field_start and char_valid are asserted together, the character SHALL belong to the new field.
REQ-028 If field_start and field_end are asserted together in CAPTURE, the old field SHALL be discarded silently and the new field opened (start wins).
REQ-029 field_end in IDLE SHALL be ignored, with no pulse.
REQ-030 fix_valid and fix_err SHALL never be high in the same cycle.

Reset
REQ-031 Reset SHALL set every digit of digits_out to DEFAULT_DIGIT, set point_pos and digit_count to 0, deassert fix_valid and fix_err, clear the shadow state, and enter IDLE.
REQ-032 Reset SHALL take priority over all other inputs, and reset asserted mid-field SHALL discard the field with no pulse.

Verification (NUM_DIGITS=8)
REQ-033 Reset, then idle -> digits_out=32'h11111111, point_pos=0, digit_count=0, no pulses.
REQ-034 start, chars "4916.4512", end -> digits_out=32'h49164512, point_pos=4, digit_count=8, fix_valid pulses exactly 1 cycle in the end cycle.
REQ-035 start, "12.5", end with the '5' sent in the same cycle as end -> digits_out=32'h12500000, point_pos=2, digit_count=3.
REQ-036 start, "49A6", end after a prior valid fix -> fix_err pulses 1 cycle and digits_out holds the prior value; same outcome for "1.2.3" and for an empty field.
REQ-037 start, "123456789", end -> digits_out=32'h12345678, digit_count=8, point_pos=8; then start, "55", start, "7", end -> digits_out=32'h70000000, with one fix_valid only.
REQ-038 start, "4916", rst asserted for 1 cycle, end -> no pulse and digits_out=32'h11111111; a repeat with NUM_DIGITS=4 and "0123" gives 16'h0123.
